// File: rtl/para.sv
// Shared definitions for the multi-port reductor.
//   HEADER_LEN  : width of the flit-type field at the flit MSBs
//   FLIT_SIZE   : default flit width in bits
//   *_FLIT      : flit-type encodings
//   arb_state_t : arbiter state (unlocked / locked to one port)
package para;

    localparam int HEADER_LEN = 2;
    localparam int FLIT_SIZE  = 64;

    localparam logic [1:0] HEAD_FLIT   = 2'b10;
    localparam logic [1:0] BODY_FLIT   = 2'b00;
    localparam logic [1:0] TAIL_FLIT   = 2'b01;
    localparam logic [1:0] SINGLE_FLIT = 2'b11;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/flit_fifo.sv
// Per-channel flit buffer.
//   clk, rst : clock, synchronous active-high reset (empties the buffer)
//   push/din : write din when push and not full
//   pop      : drop the head entry when pop and not empty
//   full     : DEPTH entries held
//   empty    : no entries held
//   head     : oldest entry (meaningful only when not empty)
module flit_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_rd;
    logic [AW-1:0]    r_wr;
    logic [AW:0]      r_count;

    logic w_push;
    logic w_pop;

    assign full   = (r_count == (AW+1)'(DEPTH));
    assign empty  = (r_count == '0);
    assign head   = r_mem[r_rd];
    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;

    // Storage carries no reset: contents are only visible through the
    // pointers, which are reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wr <= r_wr + AW'(1);
            end
            if (w_pop) begin
                r_rd <= r_rd + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + (AW+1)'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/multi_port_reductor.sv
// Merges NUM_IN flit channels into one output, keeping packets contiguous.
//   clk, rst  : clock, synchronous active-high reset
//   in_flit   : NUM_IN flits, channel i at [i*FLIT_SIZE +: FLIT_SIZE]
//   in_valid  : per-channel flit valid
//   in_avail  : per-channel buffer not full
//   out_flit  : selected flit (zero when out_valid is low)
//   out_valid : out_flit valid
//   out_avail : downstream accepts a flit this cycle
//   proto_err : sticky protocol-error flag
// Handshake: a transfer happens on a port in every cycle where its valid
// and its avail are both high; neither side waits on the other's signal
// combinationally (avail and out_valid come from registered state only).
module multi_port_reductor
    import para::*;
#(
    parameter int NUM_IN     = 4,
    parameter int FLIT_SIZE  = para::FLIT_SIZE,
    parameter int HEADER_LEN = para::HEADER_LEN,
    parameter int FIFO_DEPTH = 4,
    parameter int CMP_POS    = 61,
    parameter int CMP_LEN    = 8,
    parameter int MODE       = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_IN*FLIT_SIZE-1:0] in_flit,
    input  logic [NUM_IN-1:0]           in_valid,
    output logic [NUM_IN-1:0]           in_avail,
    output logic [FLIT_SIZE-1:0]        out_flit,
    output logic                        out_valid,
    input  logic                        out_avail,
    output logic                        proto_err
);

    localparam int PW = $clog2(NUM_IN);

    localparam logic [HEADER_LEN-1:0] T_HEAD   = HEADER_LEN'(HEAD_FLIT);
    localparam logic [HEADER_LEN-1:0] T_TAIL   = HEADER_LEN'(TAIL_FLIT);
    localparam logic [HEADER_LEN-1:0] T_SINGLE = HEADER_LEN'(SINGLE_FLIT);

    logic [NUM_IN-1:0]     w_full;
    logic [NUM_IN-1:0]     w_empty;
    logic [NUM_IN-1:0]     w_pop;
    logic [NUM_IN-1:0]     w_is_hdr;
    logic [FLIT_SIZE-1:0]  w_head  [NUM_IN];
    logic [HEADER_LEN-1:0] w_type  [NUM_IN];
    logic [CMP_LEN-1:0]    w_field [NUM_IN];

    arb_state_t   r_state;
    logic [PW-1:0] r_rr;
    logic [PW-1:0] r_lock;
    logic          r_perr;

    logic          w_cand_found;
    logic [PW-1:0] w_cand;
    logic [CMP_LEN-1:0] w_best;
    logic [PW:0]   w_sum;
    logic          w_disc_valid;
    logic [PW-1:0] w_disc;
    logic          w_disc_en;
    logic [PW-1:0] w_grant;
    logic          w_out_valid;
    logic          w_xfer;
    logic          w_lock_err;
    logic [HEADER_LEN-1:0] w_gtype;

    genvar g;
    generate
        for (g = 0; g < NUM_IN; g++) begin : g_chan
            flit_fifo #(
                .WIDTH (FLIT_SIZE),
                .DEPTH (FIFO_DEPTH)
            ) u_fifo (
                .clk   (clk),
                .rst   (rst),
                .push  (in_valid[g]),
                .din   (in_flit[g*FLIT_SIZE +: FLIT_SIZE]),
                .pop   (w_pop[g]),
                .full  (w_full[g]),
                .empty (w_empty[g]),
                .head  (w_head[g])
            );
            assign w_type[g]   = w_head[g][FLIT_SIZE-1 -: HEADER_LEN];
            assign w_field[g]  = w_head[g][CMP_POS -: CMP_LEN];
            assign w_is_hdr[g] = ~w_empty[g] &
                                 ((w_type[g] == T_HEAD) || (w_type[g] == T_SINGLE));
        end
    endgenerate

    assign in_avail = ~w_full;

    // Scan candidates in round-robin order starting after r_rr. A later
    // port only wins on a strictly larger field, so ties go to the port
    // nearest after r_rr. In MODE 1 the first candidate always wins.
    always_comb begin
        w_cand_found = 1'b0;
        w_cand       = r_rr;
        w_best       = '0;
        w_sum        = '0;
        for (int k = 1; k <= NUM_IN; k++) begin
            w_sum = {1'b0, r_rr} + (PW+1)'(k);
            if (w_sum >= (PW+1)'(NUM_IN)) begin
                w_sum = w_sum - (PW+1)'(NUM_IN);
            end
            if (w_is_hdr[w_sum[PW-1:0]] &&
                (!w_cand_found || (MODE == 0 && w_field[w_sum[PW-1:0]] > w_best))) begin
                w_cand_found = 1'b1;
                w_cand       = w_sum[PW-1:0];
                w_best       = w_field[w_sum[PW-1:0]];
            end
        end
    end

    // Lowest-index port whose head is a stray BODY/TAIL.
    always_comb begin
        w_disc_valid = 1'b0;
        w_disc       = '0;
        for (int i = NUM_IN - 1; i >= 0; i--) begin
            if (!w_empty[i] && !w_is_hdr[i]) begin
                w_disc_valid = 1'b1;
                w_disc       = PW'(i);
            end
        end
    end

    // While locked, a header at the locked port's head is never emitted:
    // it ends the lock and waits for normal arbitration.
    always_comb begin
        if (r_state == ST_LOCKED) begin
            w_grant     = r_lock;
            w_out_valid = ~w_empty[r_lock] & ~w_is_hdr[r_lock];
        end else begin
            w_grant     = w_cand;
            w_out_valid = w_cand_found;
        end
    end

    assign w_xfer     = w_out_valid & out_avail;
    assign w_disc_en  = (r_state == ST_IDLE) & ~w_out_valid & w_disc_valid;
    assign w_lock_err = (r_state == ST_LOCKED) & w_is_hdr[r_lock] & out_avail;
    assign w_gtype    = w_type[w_grant];

    always_comb begin
        w_pop = '0;
        if (w_xfer) begin
            w_pop[w_grant] = 1'b1;
        end else if (w_disc_en) begin
            w_pop[w_disc] = 1'b1;
        end
    end

    assign out_valid = w_out_valid;
    assign out_flit  = w_out_valid ? w_head[w_grant] : '0;
    assign proto_err = r_perr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_rr    <= PW'(NUM_IN - 1);
            r_lock  <= '0;
            r_perr  <= 1'b0;
        end else begin
            if (w_xfer) begin
                if (r_state == ST_IDLE) begin
                    r_rr <= w_grant;
                    if (w_gtype == T_HEAD) begin
                        r_state <= ST_LOCKED;
                        r_lock  <= w_grant;
                    end
                end else if (w_gtype == T_TAIL) begin
                    r_state <= ST_IDLE;
                end
            end else if (w_lock_err) begin
                r_state <= ST_IDLE;
                r_perr  <= 1'b1;
            end
            if (w_disc_en) begin
                r_perr <= 1'b1;
            end
        end
    end

endmodule

// File: doc/multi_port_reductor.md
MULTI_PORT_REDUCTOR -- requirements
Module: multi_port_reductor

Interface
REQ-001 Parameter NUM_IN, default 4, number of input channels (2..16).
REQ-002 Parameter FLIT_SIZE, default 64, flit width in bits.
REQ-003 Parameter HEADER_LEN, default 2, flit-type field width at flit MSBs.
REQ-004 Parameter FIFO_DEPTH, default 4, per-input buffer depth in flits (power of two, >=2).
REQ-005 Parameter CMP_POS, default 61, MSB index of priority-compare field; CMP_LEN, default 8, its width.
REQ-006 Parameter MODE, default 0; 0 = farthest-first, 1 = pure round-robin.
REQ-007 clk  input  1  clock, all logic on rising edge.
REQ-008 rst  input  1  reset, synchronous, active-high.
REQ-009 in_flit  input  NUM_IN*FLIT_SIZE  input flits; channel i at bits [i*FLIT_SIZE +: FLIT_SIZE].
REQ-010 in_valid  input  NUM_IN  per-channel flit valid.
REQ-011 in_avail  output  NUM_IN  per-channel space available (buffer not full).
REQ-012 out_flit  output  FLIT_SIZE  selected flit.
REQ-013 out_valid  output  1  out_flit valid.
REQ-014 out_avail  input  1  downstream can accept a flit this cycle.
REQ-015 proto_err  output  1  sticky protocol-error flag.

Function
REQ-016 Flit type = top HEADER_LEN bits: HEAD_FLIT, BODY_FLIT, TAIL_FLIT, SINGLE_FLIT; "header" = HEAD or SINGLE.
REQ-017 Input transfer when in_valid[i] && in_avail[i]; flit written to FIFO i; in_avail[i] = ~full[i], combinational from registered count only.
REQ-018 Output transfer when out_valid && out_avail; pops head of granted FIFO.
REQ-019 Minimum latency: flit accepted in cycle t may appear on out_flit in cycle t+1; out_flit/out_valid depend only on registered state.
REQ-020 Simultaneous push and pop on a full FIFO is not permitted (in_avail low); on non-full FIFO both occur, count unchanged.
REQ-021 States: IDLE (unlocked) and LOCKED(port p).
REQ-022 IDLE: candidates = ports whose FIFO is non-empty with a header flit at head; no candidate -> out_valid=0.
REQ-023 MODE 0: grant candidate with largest unsigned field [CMP_POS -: CMP_LEN]; ties broken round-robin from rr_ptr+1 upward, wrapping at NUM_IN-1 -> 0.
REQ-024 MODE 1: grant first candidate from rr_ptr+1 upward, wrapping.
REQ-025 On transfer of a HEAD flit from port p: rr_ptr <= p, go LOCKED(p); on SINGLE flit: rr_ptr <= p, stay IDLE.
REQ-026 LOCKED(p): only port p served; out_valid = ~empty[p]; other ports held even if non-empty.
REQ-027 LOCKED(p): on transfer of TAIL flit -> IDLE; BODY keeps lock.
REQ-028 In IDLE, a non-header flit at any FIFO head sets proto_err and is discarded (popped) without output, one per cycle, lowest index first, only when no grant occurs that cycle.
REQ-029 In LOCKED(p), a HEAD/SINGLE flit at head of p sets proto_err, terminates lock (-> IDLE) and remains queued for normal arbitration.
REQ-030 out_avail low: out_flit, out_valid, grant and state held stable.

Reset
REQ-031 On rst: all FIFOs empty, in_avail all 1s, out_valid 0, out_flit 0, state IDLE, rr_ptr NUM_IN-1, proto_err 0.
REQ-032 rst mid-packet discards all buffered flits and any lock; in-flight flits offered in the rst cycle are not accepted.

Structure
REQ-033 Flit-type encodings (HEAD 2'b10, BODY 2'b00, TAIL 2'b01, SINGLE 2'b11), HEADER_LEN and default FLIT_SIZE live in shared package para.
REQ-034 Per-channel buffer is sub-module flit_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/head), instantiated NUM_IN times via generate.
REQ-035 Arbitration is combinational over registered FIFO heads; rr_ptr, state and lock port are registers.

Verification (NUM_IN=4, FLIT_SIZE=32, CMP_POS=29, CMP_LEN=8, out_avail=1 unless stated)
REQ-036 SINGLE flits with compare fields 0x05, 0x20, 0x10, 0x20 on ports 0..3 same cycle -> outputs ports 1, 3, 2, 0 on consecutive cycles starting t+1.
REQ-037 Port 2 sends HEAD,BODY,BODY,TAIL; port 0 HEAD with higher field arrives one cycle after port 2 HEAD granted -> all 4 port-2 flits out contiguously, then port 0.
REQ-038 out_avail=0 for 10 cycles while port 1 sends 6 flits -> in_avail[1] falls after 4 accepted; no loss; all 6 flits emerge in order once out_avail=1.
REQ-039 MODE=1, all 4 ports hold back-to-back SINGLE flits -> grant order 0,1,2,3,0,1,... regardless of compare field.
REQ-040 BODY flit at port 3 head in IDLE -> proto_err=1 next cycle, flit never on out_flit; rst mid-HEAD/BODY sequence -> out_valid=0, proto_err=0, IDLE, next header arbitrated normally.
